// File: rtl/reset_synchronizer.sv
// Reset conditioner: asserts reset_no asynchronously, releases it STAGES clk_i edges after reset_ni rises.
// Define RESET_SYNC_STRETCH_EN to hold reset_no low for STRETCH_CYCLES extra edges after the chain releases.
module reset_synchronizer #(
    parameter int STAGES         = 2,
    parameter int STRETCH_CYCLES = 4
) (
    input  logic clk_i,
    input  logic reset_ni,
    output logic reset_no
);

    if (STAGES < 2) begin : g_bad_stages
        $error("reset_synchronizer: STAGES must be >= 2");
    end

    if (STRETCH_CYCLES < 1) begin : g_bad_stretch
        $error("reset_synchronizer: STRETCH_CYCLES must be >= 1");
    end

    // sync[0] -> sync[1] is the metastability-resolving path; keep these flops
    // distinct and unretimed, and treat reset_ni -> sync[*] clears as false paths.
    logic [STAGES-1:0] sync;

    // NOTE: every flop here is state, so it is updated with non-blocking (<=) assignments.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], 1'b1};
        end
    end

`ifdef RESET_SYNC_STRETCH_EN
    localparam int             CW      = $clog2(STRETCH_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STRETCH_CYCLES);

    logic [CW-1:0] cnt;
    logic          done;

    // done is registered so reset_no comes straight off a flop, not a comparator.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (sync[STAGES-1] && (cnt != CNT_MAX)) begin
            cnt  <= cnt + CW'(1);
            done <= (cnt == (CNT_MAX - CW'(1)));
        end
    end

    assign reset_no = done;
`else
    assign reset_no = sync[STAGES-1];
`endif

endmodule

// File: tb/tb_reset_synchronizer.sv
// Bench for reset_synchronizer: STAGES=2 and STAGES=3 instances share one reset input.
// Expected transitions (value, clock-edge index) are queued by stimulus and checked by monitors.
module tb_reset_synchronizer;

    localparam int STRETCH = 4;
`ifdef RESET_SYNC_STRETCH_EN
    localparam int EXTRA = STRETCH;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT2 = 2 + EXTRA;
    localparam int LAT3 = 3 + EXTRA;

    typedef struct {
        logic  val;
        int    edge_n;
        string name;
    } exp_t;

    logic clk;
    logic clk_en;
    logic reset_ni;
    logic rst2;
    logic rst3;

    int   edge_cnt;
    int   compared;
    int   mismatched;
    bit   armed;
    exp_t q2[$];
    exp_t q3[$];

    reset_synchronizer #(.STAGES(2), .STRETCH_CYCLES(STRETCH)) u_dut2 (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .reset_no (rst2)
    );

    reset_synchronizer #(.STAGES(3), .STRETCH_CYCLES(STRETCH)) u_dut3 (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .reset_no (rst3)
    );

    // 10 ns period, first rising edge at t=10; clk_en gates edges without shifting the grid.
    initial begin
        clk = 1'b0;
        #10;
        forever begin
            clk = clk_en;
            #5 clk = 1'b0;
            #5;
        end
    end

    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic expect_both(input logic val, input int lat2, input int lat3, input string name);
        exp_t e;
        e.val    = val;
        e.name   = name;
        e.edge_n = edge_cnt + lat2;
        q2.push_back(e);
        e.edge_n = edge_cnt + lat3;
        q3.push_back(e);
    endtask

    always @(rst2) begin : mon2
        exp_t e;
        if (armed) begin
            if (q2.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL s2_spurious: got %b at edge %0d expected no transition", rst2, edge_cnt);
            end else begin
                e = q2.pop_front();
                check({"s2_", e.name, "_val"}, 32'(rst2), 32'(e.val));
                check({"s2_", e.name, "_edge"}, edge_cnt, e.edge_n);
            end
        end
    end

    always @(rst3) begin : mon3
        exp_t e;
        if (armed) begin
            if (q3.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL s3_spurious: got %b at edge %0d expected no transition", rst3, edge_cnt);
            end else begin
                e = q3.pop_front();
                check({"s3_", e.name, "_val"}, 32'(rst3), 32'(e.val));
                check({"s3_", e.name, "_edge"}, edge_cnt, e.edge_n);
            end
        end
    end

    initial begin
        edge_cnt   = 0;
        compared   = 0;
        mismatched = 0;
        armed      = 1'b0;
        clk_en     = 1'b1;
        reset_ni   = 1'b1;

        // Short glitch well inside the first clock period; outputs are undefined before it.
        #3 reset_ni = 1'b0;
        #1;
        check("glitch_assert_s2", 32'(rst2), 32'd0);
        check("glitch_assert_s3", 32'(rst3), 32'd0);
        armed = 1'b1;
        #2;
        expect_both(1'b1, LAT2, LAT3, "glitch_release");
        reset_ni = 1'b1;
        #9;
        check("glitch_low_after_e1", 32'(rst2), 32'd0);
        #41;
        check("glitch_high_t56", 32'(rst2), 32'd1);

        // Long reset held across 5 edges.
        #1;
        expect_both(1'b0, 0, 0, "long_assert");
        reset_ni = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("long_held_s2", 32'(rst2), 32'd0);
        check("long_held_s3", 32'(rst3), 32'd0);
        #2;
        expect_both(1'b1, LAT2, LAT3, "long_release");
        reset_ni = 1'b1;
        repeat (LAT3 + 2) @(posedge clk);
        #1;
        check("long_high_s2", 32'(rst2), 32'd1);
        check("long_high_s3", 32'(rst3), 32'd1);

        // Async assert while the clock is stopped.
        @(negedge clk);
        clk_en = 1'b0;
        #22;
        expect_both(1'b0, 0, 0, "gated_assert");
        reset_ni = 1'b0;
        #2;
        check("gated_low_s2", 32'(rst2), 32'd0);
        check("gated_low_s3", 32'(rst3), 32'd0);
        #20;
        clk_en = 1'b1;
        @(negedge clk);
        #2;
        expect_both(1'b1, LAT2, LAT3, "gated_release");
        reset_ni = 1'b1;
        repeat (LAT3 + 2) @(posedge clk);

        // Reassert mid-release: 2 ns drop between 1st and 2nd post-release edges.
        #3;
        expect_both(1'b0, 0, 0, "mid_assert");
        reset_ni = 1'b0;
        #4 reset_ni = 1'b1;
        @(posedge clk);
        #3 reset_ni = 1'b0;
        #2;
        expect_both(1'b1, LAT2, LAT3, "mid_release");
        reset_ni = 1'b1;
        repeat (LAT3 + 3) @(posedge clk);
        #1;
        check("mid_high_s2", 32'(rst2), 32'd1);
        check("mid_high_s3", 32'(rst3), 32'd1);

        check("q2_drained", q2.size(), 32'd0);
        check("q3_drained", q3.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
